// File: rtl/truth_table_scanner_if.sv
// rtl/truth_table_scanner_if.sv - stimulus/capture bundle between the scanner and its circuit under test
interface truth_table_scanner_if;
    logic        start;
    logic        f_in;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail;
    logic        fail_valid;
    logic        pass;

    modport master (
        input  start, f_in,
        output a, b, c, d, busy, done, table_out, mismatch_count, first_fail, fail_valid, pass
    );

    modport slave (
        output start, f_in,
        input  a, b, c, d, busy, done, table_out, mismatch_count, first_fail, fail_valid, pass
    );
endinterface

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - walks all 16 input vectors, captures F and grades it against EXPECTED
module truth_table_scanner #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h8421
) (
    input logic                    clk,
    input logic                    rst,
    truth_table_scanner_if.master  bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [3:0]  settle_cnt;
    logic [15:0] table_q;
    logic [4:0]  mismatch_q;
    logic [3:0]  first_q;
    logic        fail_valid_q;
    logic        pass_q;
    logic        sample_bad;
    logic        busy_w;
    logic        done_w;
    logic [3:0]  vector;

    assign sample_bad = (bus.f_in != EXPECTED[idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_w    = 1'b0;
        done_w    = 1'b0;
        vector    = 4'd0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                busy_w = 1'b1;
                vector = idx;
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                busy_w    = 1'b1;
                vector    = idx;
                state_nxt = (idx == 4'd15) ? DONE : DRIVE;
            end
            DONE: begin
                done_w    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // mismatch_q already includes vector 15 by the time DONE grades the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= 4'd0;
            settle_cnt   <= 4'd0;
            table_q      <= 16'd0;
            mismatch_q   <= 5'd0;
            first_q      <= 4'd0;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx          <= 4'd0;
                        settle_cnt   <= 4'd0;
                        table_q      <= 16'd0;
                        mismatch_q   <= 5'd0;
                        first_q      <= 4'd0;
                        fail_valid_q <= 1'b0;
                        pass_q       <= 1'b0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    table_q[idx] <= bus.f_in;
                    if (sample_bad) begin
                        mismatch_q <= mismatch_q + 5'd1;
                        if (!fail_valid_q) begin
                            first_q      <= idx;
                            fail_valid_q <= 1'b1;
                        end
                    end
                    idx        <= (idx == 4'd15) ? 4'd0 : idx + 4'd1;
                    settle_cnt <= 4'd0;
                end
                DONE: begin
                    pass_q <= (mismatch_q == 5'd0);
                end
                default: begin
                end
            endcase
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d} = vector;
    assign bus.busy           = busy_w;
    assign bus.done           = done_w;
    assign bus.table_out      = table_q;
    assign bus.mismatch_count = mismatch_q;
    assign bus.first_fail     = first_q;
    assign bus.fail_valid     = fail_valid_q;
    assign bus.pass           = pass_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - scoreboard bench for truth_table_scanner with a table-driven circuit model
module tb_truth_table_scanner;
    localparam int          S        = 2;
    localparam int          DONE_OFF = 16 * (S + 1) + 1;
    localparam logic [15:0] EXP_MASK = 16'h8421;

    typedef struct {
        int          base;
        logic [15:0] tab;
        logic [4:0]  mc;
        logic [3:0]  ff;
        logic        fv;
        logic        ps;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ftab = 16'd0;
    int          errors = 0;
    int          checks = 0;
    int          edge_num = 0;
    exp_t        sb[$];
    logic        pend_pass = 1'b0;
    logic        exp_pass = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_num++;

    truth_table_scanner_if bus();

    truth_table_scanner #(.SETTLE_CYCLES(S), .EXPECTED(EXP_MASK)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // The circuit under test is whatever truth table the bench currently selects.
    assign bus.f_in = ftab[{bus.a, bus.b, bus.c, bus.d}];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] correct_table();
        logic [15:0] t;
        for (int k = 0; k < 16; k++) t[k] = ((k / 4) == (k % 4));
        return t;
    endfunction

    function automatic exp_t model(input int base, input logic [15:0] ft);
        exp_t        e;
        logic [15:0] diff;
        diff   = ft ^ EXP_MASK;
        e.base = base;
        e.tab  = ft;
        e.mc   = 5'($countones(diff));
        e.fv   = (diff != 16'd0);
        e.ff   = 4'd0;
        for (int k = 15; k >= 0; k--) if (diff[k]) e.ff = 4'(k);
        e.ps   = (diff == 16'd0);
        return e;
    endfunction

    always @(negedge clk) begin
        automatic int         cyc = 0;
        automatic logic       eb = 1'b0;
        automatic logic       ed = 1'b0;
        automatic logic [3:0] ev = 4'd0;
        if (!rst) begin
            if (pend_pass) check("pass", bus.pass, exp_pass);
            pend_pass = 1'b0;
            if (sb.size() > 0) begin
                cyc = edge_num - sb[0].base;
                eb  = (cyc >= 1) && (cyc < DONE_OFF);
                ed  = (cyc == DONE_OFF);
                if (eb) ev = 4'((cyc - 1) / (S + 1));
            end
            check("busy", bus.busy, eb);
            check("done", bus.done, ed);
            check("vector", {bus.a, bus.b, bus.c, bus.d}, ev);
            if (ed) begin
                check("table_out", bus.table_out, sb[0].tab);
                check("mismatch_count", bus.mismatch_count, sb[0].mc);
                check("fail_valid", bus.fail_valid, sb[0].fv);
                if (sb[0].fv) check("first_fail", bus.first_fail, sb[0].ff);
                exp_pass  = sb[0].ps;
                pend_pass = 1'b1;
                void'(sb.pop_front());
            end
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_abcd"}, {bus.a, bus.b, bus.c, bus.d}, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_table"}, bus.table_out, 0);
        check({tag, "_mcount"}, bus.mismatch_count, 0);
        check({tag, "_first"}, bus.first_fail, 0);
        check({tag, "_fvalid"}, bus.fail_valid, 0);
        check({tag, "_pass"}, bus.pass, 0);
    endtask

    task automatic start_scan(input logic [15:0] ft);
        @(negedge clk);
        ftab      = ft;
        bus.start = 1'b1;
        sb.push_back(model(edge_num, ft));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int base;
        bus.start = 1'b0;
        ftab      = correct_table();
        #1 rst = 1'b1;
        #1 reset_checks("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        start_scan(correct_table());
        wait_drain(200);
        start_scan(16'h0000);
        wait_drain(200);
        start_scan(16'hFFFF);
        wait_drain(200);
        for (int r = 0; r < 4; r++) begin
            start_scan(16'($urandom));
            if (r == 1) begin
                repeat (10) @(negedge clk);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            wait_drain(200);
        end

        // Start held high: first scan sees all-ones, rescans see the correct circuit.
        @(negedge clk);
        base      = edge_num;
        ftab      = 16'hFFFF;
        bus.start = 1'b1;
        sb.push_back(model(base, 16'hFFFF));
        for (int n = 1; n < 120; n++) begin
            @(negedge clk);
            if (n == 50) begin
                ftab = correct_table();
                sb.push_back(model(base + 50, ftab));
                sb.push_back(model(base + 100, ftab));
            end
            if (n == 51) begin
                check("rearm_table_clear", bus.table_out, 0);
                check("rearm_mcount_clear", bus.mismatch_count, 0);
                check("rearm_fvalid_clear", bus.fail_valid, 0);
                check("rearm_busy", bus.busy, 1);
            end
        end
        bus.start = 1'b0;
        wait_drain(200);

        start_scan(correct_table());
        repeat (22) @(negedge clk);
        check("abort_vector", {bus.a, bus.b, bus.c, bus.d}, 7);
        #2 rst = 1'b1;
        #1 reset_checks("abort");
        sb.delete();
        #1 rst = 1'b0;
        repeat (60) @(negedge clk);
        start_scan(correct_table());
        wait_drain(200);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
